// File: rtl/board_scanner.sv
// board_scanner
//   Sweeps every cell of one player's board through the board's registered
//   lookup port. It tallies intact ship cells, hits and misses, and flags
//   end of game. Results are shadow registers that change only when a
//   sweep completes.
//
// Ports
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   scan_start : request a full sweep (sampled only in IDLE or DONE)
//   ship_code  : cell code from the board, valid 1 cycle after ship_xy
//                (00 empty, 01 ship, 10 hit, 11 miss)
//   ship_xy    : cell address {row[2:0], col[2:0]} to the board lookup
//   busy       : sweep in progress (ISSUE or DRAIN)
//   done       : one-cycle pulse when new results are published
//   ship_cnt   : cells coded 01 in the last completed sweep
//   hit_cnt    : cells coded 10 in the last completed sweep
//   miss_cnt   : cells coded 11 in the last completed sweep
//   game_over  : last sweep found no ship cells and at least one hit
module board_scanner #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_start,
    input  logic [1:0] ship_code,
    output logic [5:0] ship_xy,
    output logic       busy,
    output logic       done,
    output logic [6:0] ship_cnt,
    output logic [6:0] hit_cnt,
    output logic [6:0] miss_cnt,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);

    state_e     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       vld_q, vld_d;
    logic [6:0] ship_acc_q, ship_acc_d;
    logic [6:0] hit_acc_q, hit_acc_d;
    logic [6:0] miss_acc_q, miss_acc_d;
    logic [6:0] ship_cnt_q, ship_cnt_d;
    logic [6:0] hit_cnt_q, hit_cnt_d;
    logic [6:0] miss_cnt_q, miss_cnt_d;
    logic       game_over_q, game_over_d;
    logic       start;
    logic       last_addr;

    always_comb begin
        start     = scan_start && ((state_q == IDLE) || (state_q == DONE));
        last_addr = (row_q == LAST_ROW) && (col_q == LAST_COL);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (last_addr) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = start ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        vld_d       = (state_q == ISSUE);
        ship_acc_d  = ship_acc_q;
        hit_acc_d   = hit_acc_q;
        miss_acc_d  = miss_acc_q;
        ship_cnt_d  = ship_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        game_over_d = game_over_q;

        // Raster address generator; the last address is held through DRAIN.
        if (start) begin
            row_d = '0;
            col_d = '0;
        end else if ((state_q == ISSUE) && !last_addr) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end else if (state_q == DRAIN) begin
            row_d = '0;
            col_d = '0;
        end

        // vld_q marks that ship_code this cycle answers last cycle's address.
        if (start) begin
            ship_acc_d = '0;
            hit_acc_d  = '0;
            miss_acc_d = '0;
        end else if (vld_q) begin
            unique case (ship_code)
                2'b01:   ship_acc_d = ship_acc_q + 7'd1;
                2'b10:   hit_acc_d  = hit_acc_q + 7'd1;
                2'b11:   miss_acc_d = miss_acc_q + 7'd1;
                default: ;
            endcase
        end

        // The final code arrives on the DRAIN->DONE edge, so publish from
        // the next-state accumulators rather than the registered ones.
        if (state_q == DRAIN) begin
            ship_cnt_d  = ship_acc_d;
            hit_cnt_d   = hit_acc_d;
            miss_cnt_d  = miss_acc_d;
            game_over_d = (ship_acc_d == '0) && (hit_acc_d != '0);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q       <= '0;
            col_q       <= '0;
            vld_q       <= 1'b0;
            ship_acc_q  <= '0;
            hit_acc_q   <= '0;
            miss_acc_q  <= '0;
            ship_cnt_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            game_over_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            vld_q       <= vld_d;
            ship_acc_q  <= ship_acc_d;
            hit_acc_q   <= hit_acc_d;
            miss_acc_q  <= miss_acc_d;
            ship_cnt_q  <= ship_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        ship_xy   = {row_q, col_q};
        ship_cnt  = ship_cnt_q;
        hit_cnt   = hit_cnt_q;
        miss_cnt  = miss_cnt_q;
        game_over = game_over_q;
    end

endmodule

// File: doc/board_scanner.md
Name: board_scanner

Overview:
- Read-side companion to the game board matrix: sweeps every cell of one player's board through the board's registered lookup port (ship_xy -> ship_code, 1-cycle latency).
- Tallies intact ship cells, hits and misses, and flags end of game.
- One instance per board (host, guest). Feeds the game FSM and the score/status display.

Parameters:
ROWS, 8, number of board rows scanned (1..8); row index occupies ship_xy[5:3]
COLS, 8, number of board columns scanned (1..8); column index occupies ship_xy[2:0]

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
scan_start  input  1  request a full board sweep; sampled only in IDLE or DONE
ship_code  input  2  cell code returned by board, valid 1 cycle after ship_xy: 00 empty, 01 ship, 10 hit, 11 miss
ship_xy  output  6  cell address {row[2:0], col[2:0]} driven to board lookup
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when new results are published
ship_cnt  output  7  cells coded 01 in last completed sweep
hit_cnt  output  7  cells coded 10 in last completed sweep
miss_cnt  output  7  cells coded 11 in last completed sweep
game_over  output  1  last completed sweep found ship_cnt==0 and hit_cnt!=0

Behaviour:
- Reset (rst==0 at edge): state IDLE. ship_xy=0, busy=0, done=0, all counts 0, game_over=0, internal accumulators and pipeline valid cleared. Reset overrides everything, including mid-sweep; no done is produced for an aborted sweep.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: scan_start=1 -> ISSUE. Accumulators are cleared on the same edge. ship_xy={0,0}.
- ISSUE: one address per cycle in raster order.
  - col increments 0..COLS-1, then wraps to 0 while row increments.
  - After address {ROWS-1, COLS-1} is issued, go to DRAIN.
  - ship_xy holds the last address in DRAIN.
- Read pipeline: a 1-bit valid register tracks each issued address. ship_code is sampled into the accumulators the cycle after its address was driven. Exactly ROWS*COLS codes are accumulated per sweep (64 at default).
- DRAIN: one cycle that accumulates the final code, then go to DONE.
- DONE: lasts one cycle.
  - done=1.
  - ship_cnt/hit_cnt/miss_cnt/game_over load from the accumulators on the edge entering DONE, so they are valid while done=1.
  - Next state is IDLE. If scan_start=1 in DONE, go directly to ISSUE instead (back-to-back sweep).
- Result outputs are shadow registers. They hold the previous sweep's values throughout a new sweep and change only on entry to DONE.
- busy=1 in ISSUE and DRAIN; 0 otherwise.
- scan_start in ISSUE/DRAIN is ignored (not queued).
- Timing at defaults, scan_start sampled at edge 0:
  - ship_xy = 0..63 in cycles 1..64.
  - Codes are sampled at edges 2..65.
  - busy=1 in cycles 1..65.
  - done=1 in cycle 66.
  - Sweep latency is ROWS*COLS+2 cycles from scan_start to done.
- Width rules: the counters saturate impossible (max 64 < 127). The accumulator increment selected by ship_code is a 2-bit case; code 00 increments nothing.
- Unused index bits beyond ROWS/COLS are never driven (e.g. ROWS=4 gives row ∈ 0..3).

Test Plan:
- All-empty board (every code 00), scan_start pulse -> done in cycle 66; ship_cnt=0, hit_cnt=0, miss_cnt=0, game_over=0; ship_xy sequence is exactly 0..63.
- Model board with ship at cells 5,6,7, hit at 20, misses at 0 and 63 -> ship_cnt=3, hit_cnt=1, miss_cnt=2, game_over=0; outputs unchanged before cycle 66.
- Board with hits at 10,11,12 and no 01 cells -> hit_cnt=3, ship_cnt=0, game_over=1. A following sweep after one hit reverts to 01 gives game_over=0.
- scan_start pulses at cycles 10 and 40 during a sweep -> ignored, single done at cycle 66. scan_start held in DONE -> next sweep starts with ship_xy=0 in cycle 67, done again in cycle 132.
- rst=0 at cycle 30 mid-sweep -> next cycle busy=0, ship_xy=0, all counts 0, no done pulse. A fresh sweep afterwards produces correct counts.
- ROWS=3, COLS=5 -> ship_xy visits {0,0}..{0,4},{1,0}..{2,4} (15 addresses, never col 5..7), done 17 cycles after scan_start.
